// File: rtl/ram_sp_mask.sv
// Single-port masked RAM with a post-reset init sweep, read-valid strobe and
// out-of-range flag; read latency 1 cycle; no backpressure, requests ignored while BUSY.
// Optional even-parity per word via `define RAM_SP_MASK_PARITY_EN (PERR tied low otherwise).
module ram_sp_mask #(
    parameter int          DW       = 8,
    parameter int          AW       = 4,
    parameter int          DEPTH    = 16,
    parameter logic [DW-1:0] INIT_VAL = '0
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          EN,
    input  logic          WR,
    input  logic [AW-1:0] A,
    input  logic [DW-1:0] D,
    input  logic [DW-1:0] M,
    output logic [DW-1:0] Q,
    output logic          QV,
    output logic          BUSY,
    output logic          ERR,
    output logic          PERR
);

    typedef enum logic {ST_INIT, ST_IDLE} state_t;

    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    state_t        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;

    logic [DW-1:0] mem [DEPTH];

    logic          in_range;
    logic          req_vld;
    logic          do_wr;
    logic          do_rd;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdat;

    assign in_range = (32'(A) < DEPTH);
    assign req_vld  = (state_q == ST_IDLE) && EN;
    assign do_wr    = req_vld && in_range && WR;
    assign do_rd    = req_vld && in_range && !WR;
    assign BUSY     = (state_q == ST_INIT);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == ST_INIT) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST) begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        end
    end

    // The sweep owns the write port until it finishes; user writes merge under the mask.
    always_comb begin
        mem_we   = 1'b0;
        mem_addr = A;
        mem_wdat = (mem[A] & ~M) | (D & M);
        if (state_q == ST_INIT) begin
            mem_we   = 1'b1;
            mem_addr = cnt_q;
            mem_wdat = INIT_VAL;
        end else if (do_wr) begin
            mem_we   = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_wdat;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
            Q       <= '0;
            QV      <= 1'b0;
            ERR     <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            QV      <= do_rd;
            ERR     <= req_vld && !in_range;
            if (do_rd) begin
                Q <= mem[A];
            end
        end
    end

`ifdef RAM_SP_MASK_PARITY_EN
    logic par_mem [DEPTH];
    logic perr_q;

    always_ff @(posedge CLK) begin
        if (mem_we) begin
            par_mem[mem_addr] <= ^mem_wdat;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            perr_q <= 1'b0;
        end else begin
            perr_q <= do_rd && ((^mem[A]) != par_mem[A]);
        end
    end

    assign PERR = perr_q;
`else
    assign PERR = 1'b0;
`endif

endmodule

// File: tb/tb_ram_sp_mask.sv
// Randomised scoreboard bench for ram_sp_mask (DW=8, AW=4, DEPTH=12, INIT_VAL=A5).
module tb_ram_sp_mask;

    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 12;
    localparam logic [DW-1:0] IV = 8'hA5;

    logic          CLK = 1'b0;
    logic          RST_N = 1'b0;
    logic          EN = 1'b0;
    logic          WR = 1'b0;
    logic [AW-1:0] A = '0;
    logic [DW-1:0] D = '0;
    logic [DW-1:0] M = '0;
    logic [DW-1:0] Q;
    logic          QV, BUSY, ERR, PERR;

    ram_sp_mask #(.DW(DW), .AW(AW), .DEPTH(DEPTH), .INIT_VAL(IV)) dut (
        .CLK(CLK), .RST_N(RST_N), .EN(EN), .WR(WR), .A(A), .D(D), .M(M),
        .Q(Q), .QV(QV), .BUSY(BUSY), .ERR(ERR), .PERR(PERR)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        bit            is_err;
        logic [DW-1:0] q;
    } exp_t;

    exp_t          sb [$];
    logic [DW-1:0] model [DEPTH];
    logic [DW-1:0] last_q;
    int            n_cmp = 0;
    int            n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_init();
        for (int i = 0; i < DEPTH; i++) model[i] = IV;
    endtask

    // One request presented for the next rising edge; the expected response is queued.
    task automatic req(input bit en, input bit wr, input int a, input logic [DW-1:0] d,
                       input logic [DW-1:0] m);
        exp_t e;
        @(negedge CLK);
        EN = en; WR = wr; A = AW'(a); D = d; M = m;
        if (en) begin
            if (a >= DEPTH) begin
                e.is_err = 1'b1; e.q = last_q; sb.push_back(e);
            end else if (wr) begin
                model[a] = (model[a] & ~m) | (d & m);
            end else begin
                last_q = model[a];
                e.is_err = 1'b0; e.q = last_q; sb.push_back(e);
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) req(1'b0, 1'b0, 0, 8'h00, 8'h00);
    endtask

    task automatic count_busy(input string name);
        int busy_n;
        busy_n = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge CLK);
            if (BUSY) busy_n++;
            else break;
        end
        EN = 1'b0;
        chk(name, busy_n, DEPTH);
    endtask

    always @(negedge CLK) begin
        if (RST_N && (QV || ERR)) begin
            if (sb.size() == 0) begin
                chk("unexpected_pulse", {30'd0, QV, ERR}, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("pulse_kind", {30'd0, QV, ERR}, e.is_err ? 32'd1 : 32'd2);
                chk("q_data", Q, e.q);
                chk("perr", PERR, 0);
            end
        end
    end

    initial begin
        last_q = '0;
        model_init();
        repeat (2) @(negedge CLK);
        chk("rst_q", Q, 0);
        chk("rst_qv", QV, 0);
        chk("rst_err", ERR, 0);
        chk("rst_perr", PERR, 0);
        chk("rst_busy", BUSY, 1);

        // Release with a write to address 0 held active through the sweep.
        @(posedge CLK); #1;
        RST_N = 1'b1;
        EN = 1'b1; WR = 1'b1; A = '0; D = 8'h11; M = 8'hFF;
        count_busy("busy_len");

        for (int i = 0; i < DEPTH; i++) req(1'b1, 1'b0, i, 8'h00, 8'h00);
        idle(1);

        // Masked and zero-mask writes.
        req(1'b1, 1'b1, 3, 8'hFF, 8'h0F);
        req(1'b1, 1'b0, 3, 8'h00, 8'h00);
        req(1'b1, 1'b1, 3, 8'h00, 8'h00);
        req(1'b1, 1'b0, 3, 8'h00, 8'h00);
        idle(2);
        chk("masked_model", model[3], 8'hAF);

        // Out-of-range accesses.
        req(1'b1, 1'b0, 13, 8'h00, 8'h00);
        req(1'b1, 1'b1, 12, 8'h3C, 8'hFF);
        req(1'b1, 1'b0, 11, 8'h00, 8'h00);
        req(1'b1, 1'b1, 15, 8'h3C, 8'hFF);
        idle(2);

        for (int i = 0; i < 400; i++) begin
            logic [DW-1:0] m;
            case ($urandom_range(0, 3))
                0: m = 8'h00;
                1: m = 8'hFF;
                default: m = 8'($urandom);
            endcase
            req($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                int'($urandom_range(0, 15)), 8'($urandom), m);
        end
        idle(3);
        chk("sb_drained_1", sb.size(), 0);

        // Reset in IDLE clears Q immediately.
        @(posedge CLK); #2;
        RST_N = 1'b0;
        #1;
        chk("arst_q", Q, 0);
        chk("arst_busy", BUSY, 1);
        chk("arst_qv", QV, 0);
        last_q = '0;
        model_init();

        // Reset again part-way through the sweep; it must restart in full.
        @(posedge CLK); #1;
        RST_N = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            chk("sweep_busy", BUSY, 1);
        end
        #1;
        RST_N = 1'b0;
        #1;
        chk("mid_rst_busy", BUSY, 1);
        chk("mid_rst_q", Q, 0);
        @(posedge CLK); #1;
        RST_N = 1'b1;
        count_busy("busy_len_restart");

        for (int i = 0; i < DEPTH; i++) req(1'b1, 1'b0, i, 8'h00, 8'h00);
        idle(3);
        chk("sb_drained_2", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
